// File: rtl/lsu_pkg.sv
// Shared load-unit definitions: funct3 load encodings, FSM state type, fault rule.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // A request faults when its type is not a load, or its address is not aligned to the access size.
  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = addr_lo[0];
      F3_LW:         fault = (addr_lo != 2'b00);
      default:       fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational byte/half/word extraction from a memory word, with sign or zero extension.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = 8'h00;
    half_val = 16'h0000;
    data     = 32'h0000_0000;

    case (addr_lo)
      2'b00:   byte_val = word[7:0];
      2'b01:   byte_val = word[15:8];
      2'b10:   byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase

    half_val = addr_lo[1] ? word[31:16] : word[15:0];

    // Unsupported encodings deliberately produce zero.
    case (funct3)
      F3_LB:   data = {{24{byte_val[7]}}, byte_val};
      F3_LBU:  data = {24'h000000, byte_val};
      F3_LH:   data = {{16{half_val[15]}}, half_val};
      F3_LHU:  data = {16'h0000, half_val};
      F3_LW:   data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: IDLE -> ISSUE -> (WAIT) -> RESP with valid/ready on both sides.
// Defining LSU_MISALIGN_TRAP_EN sends misaligned or illegal loads straight to a faulting response.
module load_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_fault
);

  localparam logic [1:0] CNT_INIT = 2'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic [31:0] word_q;
  logic        fault_q;
  logic [1:0]  cnt_q;
  logic        accept;
  logic        req_fault;
  logic        capture;
  logic [31:0] aligned;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_fault = load_fault(req_funct3, req_addr[1:0]);
`else
  assign req_fault = 1'b0;
`endif

  assign accept  = req_valid && req_ready;
  assign capture = ((state_q == ST_ISSUE) && (MEM_LATENCY == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == 2'd0));

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 32'h0000_0000;
    rsp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_fault ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_re   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        state_d  = (MEM_LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      rd_q     <= 5'd0;
      word_q   <= 32'h0000_0000;
      fault_q  <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        rd_q     <= req_rd;
        fault_q  <= req_fault;
        word_q   <= 32'h0000_0000;
      end
      if (state_q == ST_ISSUE) cnt_q <= CNT_INIT;
      else if ((state_q == ST_WAIT) && (cnt_q != 2'd0)) cnt_q <= cnt_q - 2'd1;
      if (capture) word_q <= mem_rdata;
    end
  end

  load_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .word    (word_q),
    .data    (aligned)
  );

  // Response fields are forced to zero outside RESP so they read clean during reset and idle.
  assign rsp_data = (rsp_valid && !fault_q) ? aligned : 32'h0000_0000;
  assign rsp_rd   = rsp_valid ? rd_q : 5'd0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_fault = rsp_valid && fault_q;
`else
  assign rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit (MEM_LATENCY=2): vector table, random loads and reset corners.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_unit;
  import lsu_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  load_unit #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_fault  (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'd1) return 32'h8081_F2F3;
    return ({a[31:2], 2'b00} * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory returns the real word only LAT cycles after the strobe; anything else reads as junk.
  logic [3:0]  re_hist;
  logic [31:0] addr_hist [4];
  always @(posedge clk) begin
    if (!rst_n) re_hist <= 4'b0000;
    else re_hist <= {re_hist[2:0], mem_re};
    addr_hist[0] <= mem_addr;
    for (int i = 1; i < 4; i++) addr_hist[i] <= addr_hist[i-1];
  end
  assign mem_rdata = re_hist[LAT-1] ? mem_word(addr_hist[LAT-1]) : 32'hDEAD_BEEF;

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    exp_t r;
    logic [31:0] w;
    logic [31:0] sh;
    w = mem_word(a);
    sh = w >> (8 * a[1:0]);
    r.rd = rd;
    r.fault = 1'b0;
    r.data = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[1:0] == 2'b01 && a[0]) ||
        (f3 == 3'b010 && a[1:0] != 2'b00)) begin
      r.fault = 1'b1;
      return r;
    end
`endif
    case (f3)
      3'b000: r.data = {{24{sh[7]}}, sh[7:0]};
      3'b100: r.data = {24'h0, sh[7:0]};
      3'b001: begin sh = w >> (16 * a[1]); r.data = {{16{sh[15]}}, sh[15:0]}; end
      3'b101: begin sh = w >> (16 * a[1]); r.data = {16'h0, sh[15:0]}; end
      3'b010: r.data = w;
      default: r.data = 32'h0;
    endcase
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full load: request, track issue and latency, hold the response, then handshake and score.
  task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                                input int hold, input logic [31:0] exp_data, input logic exp_fault);
    int lat;
    int re_cnt;
    logic [31:0] d0;
    logic [4:0]  r0;
    logic        f0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_funct3 = f3;
    req_addr = addr;
    req_rd = rd;
    check_output("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_funct3 = ~f3;
    req_addr = ~addr;
    req_rd = ~rd;
    sb.push_back(exp_t'{exp_data, rd, exp_fault});
    lat = 0;
    re_cnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_re) begin
        re_cnt++;
        check_output("mem_addr", mem_addr, {addr[31:2], 2'b00});
      end else begin
        check_output("mem_addr_quiet", mem_addr, 32'h0);
      end
      if (rsp_valid) break;
    end
    check_output("latency", lat, exp_fault ? 32'd1 : 32'(LAT + 2));
    check_output("mem_re_count", re_cnt, exp_fault ? 32'd0 : 32'd1);
    d0 = rsp_data;
    r0 = rsp_rd;
    f0 = rsp_fault;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check_output("hold_data", rsp_data, d0);
      check_output("hold_rd", {27'b0, rsp_rd}, {27'b0, r0});
      check_output("hold_fault", {31'b0, rsp_fault}, {31'b0, f0});
      check_output("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    check_output("hs_req_ready", {31'b0, req_ready}, 32'd0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check_output("rsp_data", rsp_data, e.data);
      check_output("rsp_rd", {27'b0, rsp_rd}, {27'b0, e.rd});
      check_output("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_output("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    exp_t m;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    logic [4:0]  rrd;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_rd = 5'd0;
    rsp_ready = 1'b0;

    tbl.push_back(vec_t'{F3_LB,  32'h7, 5'd1, 0, 32'hFFFF_FF80, 1'b0});
    tbl.push_back(vec_t'{F3_LBU, 32'h6, 5'd2, 0, 32'h0000_0081, 1'b0});
    tbl.push_back(vec_t'{F3_LH,  32'h4, 5'd3, 1, 32'hFFFF_F2F3, 1'b0});
    tbl.push_back(vec_t'{F3_LHU, 32'h6, 5'd4, 0, 32'h0000_8081, 1'b0});
    tbl.push_back(vec_t'{F3_LW,  32'h4, 5'd5, 3, 32'h8081_F2F3, 1'b0});
    tbl.push_back(vec_t'{F3_LB,  32'h4, 5'd6, 0, 32'hFFFF_FFF3, 1'b0});
    tbl.push_back(vec_t'{F3_LBU, 32'h5, 5'd7, 0, 32'h0000_00F2, 1'b0});
    tbl.push_back(vec_t'{F3_LH,  32'h6, 5'd8, 0, 32'hFFFF_8081, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(vec_t'{F3_LW,  32'h6, 5'd10, 1, 32'h0, 1'b1});
    tbl.push_back(vec_t'{F3_LH,  32'h5, 5'd11, 0, 32'h0, 1'b1});
    tbl.push_back(vec_t'{3'b011, 32'h4, 5'd12, 0, 32'h0, 1'b1});
    tbl.push_back(vec_t'{3'b110, 32'h4, 5'd13, 0, 32'h0, 1'b1});
    tbl.push_back(vec_t'{3'b111, 32'h4, 5'd14, 0, 32'h0, 1'b1});
`else
    tbl.push_back(vec_t'{F3_LW,  32'h6, 5'd10, 1, 32'h8081_F2F3, 1'b0});
    tbl.push_back(vec_t'{F3_LH,  32'h5, 5'd11, 0, 32'hFFFF_F2F3, 1'b0});
    tbl.push_back(vec_t'{F3_LHU, 32'h7, 5'd15, 0, 32'h0000_8081, 1'b0});
    tbl.push_back(vec_t'{3'b011, 32'h4, 5'd12, 0, 32'h0, 1'b0});
    tbl.push_back(vec_t'{3'b110, 32'h4, 5'd13, 0, 32'h0, 1'b0});
    tbl.push_back(vec_t'{3'b111, 32'h4, 5'd14, 0, 32'h0, 1'b0});
`endif

    #23;
    check_output("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check_output("reset_mem_re", {31'b0, mem_re}, 32'd0);
    check_output("reset_mem_addr", mem_addr, 32'h0);
    check_output("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("reset_rsp_data", rsp_data, 32'h0);
    check_output("reset_rsp_rd", {27'b0, rsp_rd}, 32'd0);
    check_output("reset_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      apply_stimulus(tbl[i].f3, tbl[i].addr, tbl[i].rd, tbl[i].hold, tbl[i].exp_data, tbl[i].exp_fault);

    for (int i = 0; i < 16; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      raddr = 32'($urandom_range(0, 63));
      rrd = 5'($urandom_range(0, 31));
      m = model(rf3, raddr, rrd);
      apply_stimulus(rf3, raddr, rrd, $urandom_range(0, 2), m.data, m.fault);
    end

    // Reset while waiting on memory must abandon the load cleanly.
    @(negedge clk);
    req_valid = 1'b1;
    req_funct3 = F3_LW;
    req_addr = 32'h4;
    req_rd = 5'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sb.push_back(exp_t'{32'h8081_F2F3, 5'd9, 1'b0});
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("midreset_mem_re", {31'b0, mem_re}, 32'd0);
    check_output("midreset_req_ready", {31'b0, req_ready}, 32'd1);
    check_output("midreset_rsp_rd", {27'b0, rsp_rd}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    check_output("inreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    apply_stimulus(F3_LW, 32'h4, 5'd19, 0, 32'h8081_F2F3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 0, meaning cycles from the mem_re cycle to the mem_rdata capture cycle (legal 0..3).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  load request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-006 SHALL have port req_funct3  input  3  load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_rd  input  5  destination tag, returned unchanged.
REQ-009 SHALL have port mem_re  output  1  memory read strobe.
REQ-010 SHALL have port mem_addr  output  32  word-aligned address, low two bits forced to 0.
REQ-011 SHALL have port mem_rdata  input  32  full memory word.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have port rsp_data  output  32  aligned and extended load result.
REQ-015 SHALL have port rsp_rd  output  5  tag of the response.
REQ-016 SHALL have port rsp_fault  output  1  misaligned or illegal-type load.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> (WAIT when MEM_LATENCY>0) -> RESP -> IDLE.
REQ-018 SHALL drive req_ready high only in IDLE; on accept, latch funct3, addr and rd, then enter ISSUE.
REQ-019 SHALL assert mem_re for exactly one cycle, in ISSUE, with mem_addr = {addr[31:2],2'b00}; mem_addr SHALL be 0 when mem_re is low.
REQ-020 SHALL capture mem_rdata in ISSUE if MEM_LATENCY=0, otherwise in the last of MEM_LATENCY WAIT cycles tracked by a down-counter.
REQ-021 SHALL give an accept-to-rsp_valid latency of MEM_LATENCY+2 cycles.
REQ-022 SHALL select byte addr[1:0] for lb/lbu, select half addr[1] for lh/lhu, and sign-extend lb/lh or zero-extend lbu/lhu to 32 bits.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_rd and rsp_fault stable in RESP until rsp_ready; the handshake cycle returns the FSM to IDLE.
REQ-024 SHALL NOT accept a new request in the rsp handshake cycle; the next accept occurs in IDLE at the earliest.
REQ-025 SHALL return rsp_data=0 for funct3 011, 110 and 111.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-transaction, enter IDLE, discard the transaction, and drive every output to 0 except req_ready, which SHALL be 1 while in IDLE after reset.

Configuration
REQ-027 SHALL support macro LSU_MISALIGN_TRAP_EN.
REQ-028 With LSU_MISALIGN_TRAP_EN defined, lh/lhu with addr[0]=1, lw with addr[1:0]!=0, and illegal funct3 SHALL go IDLE -> RESP directly with rsp_fault=1 and rsp_data=0, and no mem_re is issued.
REQ-029 Without LSU_MISALIGN_TRAP_EN, rsp_fault SHALL be tied 0, address bits below the access size SHALL be ignored, and the normal path is used.

Structure
REQ-030 Package lsu_pkg SHALL hold the funct3 load-type constants and the FSM state typedef.
REQ-031 SHALL place the extract/extend logic in combinational sub-module load_align.

Verification
REQ-032 Word 0x8081F2F3 at 0x4: lb 0x7 -> 0xFFFFFF80; lbu 0x6 -> 0x00000081; lh 0x4 -> 0xFFFFF2F3; lhu 0x6 -> 0x00008081; lw 0x4 -> 0x8081F2F3.
REQ-033 MEM_LATENCY=2, accept in cycle 0 -> mem_re in cycle 1, capture in cycle 3, rsp_valid in cycle 4.
REQ-034 rsp_ready held low for 3 cycles in RESP -> rsp outputs unchanged and req_ready=0 throughout; the handshake returns the FSM to IDLE.
REQ-035 lw 0x6 with macro -> rsp_fault=1, rsp_data=0, mem_re never high; without macro -> rsp_data=0x8081F2F3, rsp_fault=0.
REQ-036 rst_n low during WAIT -> rsp_valid=0 and mem_re=0 at once; a following lw 0x4 completes normally with tag preserved.
